// File: rtl/divider_control.sv
// divider_control
//   Control FSM for a restoring-division datapath (8-bit dividend, 7-bit
//   divisor, 8-bit quotient, 7-bit remainder). One division per accepted
//   start: LOAD, then N iterations of SHIFT / SUB / DECIDE, then a one-cycle
//   DONE during which the datapath quotient/remainder are valid.
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-low; forces IDLE and all outputs to 0
//   start  in   division request, sampled only in IDLE and DONE
//   sign   in   registered datapath borrow flag (1 = last subtract negative)
//   load   out  datapath loads operands and clears the remainder
//   add    out  enables the datapath ALU write to the remainder
//   shift  out  shifts {remainder, quotient} left, inbit enters quotient[0]
//   inbit  out  bit written into quotient[0] on shift / set-bit
//   sel    out  00 hold, 01 rem-div, 10 rem+div (restore), 11 quotient[0]<=inbit
//   busy   out  high while a division is in progress
//   done   out  one-cycle pulse, results valid
module divider_control #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       sign,
  output logic       load,
  output logic       add,
  output logic       shift,
  output logic       inbit,
  output logic [1:0] sel,
  output logic       busy,
  output logic       done
);

  // Guard against a zero-width counter when N is 1.
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  localparam logic [1:0] SEL_HOLD = 2'b00;
  localparam logic [1:0] SEL_SUB  = 2'b01;
  localparam logic [1:0] SEL_ADD  = 2'b10;
  localparam logic [1:0] SEL_SET  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    SUB    = 3'd3,
    DECIDE = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  // State register and iteration counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. start is only looked at in IDLE and DONE, so a request
  // arriving mid-division is dropped rather than queued.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: state_nxt = SUB;
      SUB:   state_nxt = DECIDE;
      DECIDE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CNT_W'(1);
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        state_nxt = start ? LOAD : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. sign is consulted only in DECIDE, so an unknown borrow
  // flag in any other state cannot reach the outputs.
  always_comb begin
    load  = 1'b0;
    add   = 1'b0;
    shift = 1'b0;
    inbit = 1'b0;
    sel   = SEL_HOLD;
    busy  = 1'b0;
    done  = 1'b0;
    case (state)
      LOAD: begin
        load = 1'b1;
        busy = 1'b1;
      end
      SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      SUB: begin
        add  = 1'b1;
        sel  = SEL_SUB;
        busy = 1'b1;
      end
      DECIDE: begin
        busy = 1'b1;
        if (sign) begin
          // Subtract went negative: add the divisor back, quotient bit stays 0.
          add = 1'b1;
          sel = SEL_ADD;
        end else begin
          inbit = 1'b1;
          sel   = SEL_SET;
        end
      end
      DONE: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_divider_control.sv
module tb_divider_control;

  localparam int N = 8;
  localparam int LAST_J = 3 * N + 1;

  logic       clk;
  logic       reset;
  logic       start;
  logic       sign;
  logic       load;
  logic       add;
  logic       shift;
  logic       inbit;
  logic [1:0] sel;
  logic       busy;
  logic       done;

  divider_control #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .sign  (sign),
    .load  (load),
    .add   (add),
    .shift (shift),
    .inbit (inbit),
    .sel   (sel),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural restoring-division datapath driven by the controller strobes.
  logic [7:0] dividendin;
  logic [6:0] divisorin;
  logic [7:0] dp_q;
  logic [7:0] dp_r;
  logic [6:0] dp_d;
  logic       dp_sign;
  logic [8:0] diff;

  assign diff = {1'b0, dp_r} - {2'b00, dp_d};

  always @(posedge clk) begin
    if (load) begin
      dp_q    <= dividendin;
      dp_r    <= 8'd0;
      dp_d    <= divisorin;
      dp_sign <= 1'b0;
    end else if (shift) begin
      {dp_r, dp_q} <= {dp_r[6:0], dp_q, inbit};
    end else if (add && sel == 2'b01) begin
      dp_r    <= diff[7:0];
      dp_sign <= diff[8];
    end else if (add && sel == 2'b10) begin
      dp_r <= dp_r + {1'b0, dp_d};
    end else if (sel == 2'b11) begin
      dp_q[0] <= inbit;
    end
  end

  // Output bundle: {load, add, shift, inbit, sel, busy, done}
  logic [7:0] outv;
  assign outv = {load, add, shift, inbit, sel, busy, done};

  localparam logic [7:0] O_IDLE = 8'b0000_0000;
  localparam logic [7:0] O_LOAD = 8'b1000_0010;
  localparam logic [7:0] O_SHFT = 8'b0010_0010;
  localparam logic [7:0] O_SUB  = 8'b0100_0110;
  localparam logic [7:0] O_RST  = 8'b0100_1010;
  localparam logic [7:0] O_SET  = 8'b0001_1110;
  localparam logic [7:0] O_DONE = 8'b0000_0001;

  int n_pass;
  int n_total;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if ($isunknown(act) || act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      n_pass++;
  endfunction

  // Expected strobes for cycle j of a division (j=0 is the LOAD cycle),
  // taken from the schedule: LOAD, N x {SHIFT, SUB, DECIDE}, DONE. The
  // DECIDE branch follows the quotient bit produced by that iteration.
  function automatic logic [7:0] exp_out(int j, logic [7:0] q);
    int k;
    if (j == 0) return O_LOAD;
    if (j == LAST_J) return O_DONE;
    k = (j - 1) / 3;
    case ((j - 1) % 3)
      0: return O_SHFT;
      1: return O_SUB;
      default: return q[N-1-k] ? O_SET : O_RST;
    endcase
  endfunction

  task automatic kick();
    @(posedge clk) #1;
    start = 1'b1;
    sign  = 1'($urandom);
    @(negedge clk);
    chk("idle_with_start", outv, O_IDLE);
    @(posedge clk) #1;
  endtask

  // Entered at the start of the LOAD cycle. stray_j: cycle in which a
  // spurious start is pulsed (-1 none). abort_j: cycle in which reset is
  // dropped (-1 none). hold: keep start high through DONE.
  task automatic run(input logic [7:0] a, input logic [6:0] b,
                     input logic [7:0] eq, input logic [6:0] er, input bit chk_r,
                     input int stray_j, input int abort_j, input bit hold);
    dividendin = a;
    divisorin  = b;
    for (int j = 0; j <= LAST_J; j++) begin
      start = (j == stray_j) || (hold && j == LAST_J);
      if (j >= 1 && j < LAST_J && (j - 1) % 3 == 2)
        sign = dp_sign;
      else
        sign = 1'($urandom);
      if (j == abort_j) begin
        reset = 1'b0;
        #1;
        chk("reset_async", outv, O_IDLE);
        for (int c = 0; c < 2; c++) begin
          @(posedge clk) #1;
          start = ~start;
          @(negedge clk);
          chk("reset_held", outv, O_IDLE);
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk) #1;
        @(negedge clk);
        chk("after_reset_idle", outv, O_IDLE);
        return;
      end
      @(negedge clk);
      chk($sformatf("ctl_%0d_%0d_j%0d", a, b, j), outv, exp_out(j, eq));
      if (j == LAST_J) begin
        chk($sformatf("quot_%0d_%0d", a, b), dp_q, eq);
        if (chk_r) chk($sformatf("rem_%0d_%0d", a, b), dp_r, {1'b0, er});
      end
      @(posedge clk) #1;
    end
    if (!hold) begin
      start = 1'b0;
      sign  = 1'($urandom);
      @(negedge clk);
      chk("idle_after_done", outv, O_IDLE);
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [6:0] b;
    logic [7:0] q;
    logic [6:0] r;
    bit         chk_r;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    vecs[0] = '{8'd100, 7'd7,   8'd14,  7'd2, 1'b1};
    vecs[1] = '{8'd255, 7'd1,   8'd255, 7'd0, 1'b1};
    vecs[2] = '{8'd0,   7'd5,   8'd0,   7'd0, 1'b1};
    vecs[3] = '{8'd127, 7'd127, 8'd1,   7'd0, 1'b1};
    vecs[4] = '{8'd200, 7'd13,  8'd15,  7'd5, 1'b1};
    vecs[5] = '{8'd255, 7'd127, 8'd2,   7'd1, 1'b1};
    vecs[6] = '{8'd1,   7'd127, 8'd0,   7'd1, 1'b1};
    vecs[7] = '{8'd128, 7'd3,   8'd42,  7'd2, 1'b1};
    vecs[8] = '{8'd200, 7'd0,   8'd255, 7'd0, 1'b0};

    dividendin = 8'd0;
    divisorin  = 7'd0;
    reset = 1'b0;
    start = 1'b0;
    sign  = 1'b0;

    // Reset held with start toggling, then released with start low.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk) #1;
      start = ~start;
      sign  = 1'($urandom);
      @(negedge clk);
      chk("in_reset", outv, O_IDLE);
    end
    start = 1'b0;
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk) #1;
      @(negedge clk);
      chk("post_release", outv, O_IDLE);
    end

    // Table-driven divisions.
    for (int i = 0; i < 9; i++) begin
      kick();
      run(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].chk_r, -1, -1, 1'b0);
    end

    // Spurious start during SUB of iteration 2 is ignored.
    kick();
    run(8'd100, 7'd7, 8'd14, 7'd2, 1'b1, 2 + 3 * 2, -1, 1'b0);

    // Reset dropped in SHIFT of iteration 3, then a clean division.
    kick();
    run(8'd100, 7'd7, 8'd14, 7'd2, 1'b1, -1, 1 + 3 * 3, 1'b0);
    kick();
    run(8'd100, 7'd7, 8'd14, 7'd2, 1'b1, -1, -1, 1'b0);

    // Back-to-back: start held through DONE.
    kick();
    run(8'd100, 7'd7, 8'd14, 7'd2, 1'b1, -1, -1, 1'b1);
    run(8'd255, 7'd1, 8'd255, 7'd0, 1'b1, -1, -1, 1'b0);

    // Randomized operands against plain integer division.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] ra;
      logic [6:0] rb;
      ra = 8'($urandom);
      rb = 7'($urandom_range(1, 127));
      kick();
      run(ra, rb, 8'(ra / rb), 7'(ra % rb), 1'b1, -1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
